// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Stalls the front of the pipeline until the result is registered.
module muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2:0]      f3_q, f3_d;
    logic [W-1:0]    a_abs_q, a_abs_d, b_abs_q, b_abs_d;
    logic [W-1:0]    a_raw_q, a_raw_d, b_raw_q, b_raw_d;
    logic            neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [W-1:0]    result_q, result_d;
    logic            done_q, done_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic            is_div, div_zero, div_ovf;
    logic [W-1:0]    special_res;
    logic [W:0]      mul_sum, rem_sh, rem_sub;
    logic [2*W-1:0]  mul_next, div_next, prod_fix;
    logic [W-1:0]    quot_fix, rem_fix, fix_res;

    // Operand signedness/magnitude decode for the capture in IDLE
    always_comb begin
        a_signed = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
        b_signed = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
        a_neg    = a_signed & SrcA[W-1];
        b_neg    = b_signed & SrcB[W-1];
        a_abs_d  = a_neg ? -SrcA : SrcA;
        b_abs_d  = b_neg ? -SrcB : SrcB;
    end

    // Datapath: special-case detection, one iteration step, final sign fix-up
    always_comb begin
        is_div      = f3_q[2];
        div_zero    = is_div && (b_raw_q == '0);
        div_ovf     = is_div && !f3_q[0] && (a_raw_q == MOST_NEG) && (b_raw_q == '1);
        special_res = '0;
        if (div_zero)
            special_res = f3_q[1] ? a_raw_q : '1;
        else if (div_ovf)
            special_res = f3_q[1] ? '0 : a_raw_q;

        // multiplier sits in the low half and is consumed LSB-first
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_abs_q} : '0);
        mul_next = {mul_sum, acc_q[W-1:1]};

        // borrow out of the W+1-bit subtract means remainder < divisor
        rem_sh  = acc_q[2*W-1:W-1];
        rem_sub = rem_sh - {1'b0, b_abs_q};
        if (!rem_sub[W])
            div_next = {rem_sub[W-1:0], acc_q[W-2:0], 1'b1};
        else
            div_next = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quot_fix = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        if (!f3_q[2])
            fix_res = (f3_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        else
            fix_res = f3_q[1] ? rem_fix : quot_fix;
    end

    // Next-state and register-update logic; flush overrides everything
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        f3_d      = f3_q;
        a_raw_d   = a_raw_q;
        b_raw_d   = b_raw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    f3_d      = Funct3;
                    a_raw_d   = SrcA;
                    b_raw_d   = SrcB;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    state_d   = PREP;
                end
            end
            PREP: begin
                cnt_d = '0;
                acc_d = '0;
                if (div_zero || div_ovf) begin
                    result_d = special_res;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    acc_d   = {{W{1'b0}}, (is_div ? a_abs_q : b_abs_q)};
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = is_div ? div_next : mul_next;
                if (cnt_q == LAST_ITER)
                    state_d = FIX;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            FIX: begin
                result_d = fix_res;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
            done_d   = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            f3_q      <= '0;
            a_abs_q   <= '0;
            b_abs_q   <= '0;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            f3_q      <= f3_d;
            if (state_q == IDLE && start) begin
                a_abs_q <= a_abs_d;
                b_abs_q <= b_abs_d;
            end
            a_raw_q   <= a_raw_d;
            b_raw_q   <= b_raw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign Result = result_q;
    assign stall  = reset && !flush &&
                    ((state_q == IDLE && start) ||
                     state_q == PREP || state_q == CALC || state_q == FIX);

endmodule
